vfifo_wr_scheduler: RTL
=======================

Name: vfifo_wr_scheduler

Overview:
- Write-side sequencer of the AXI4-Stream virtual FIFO.
- Consumes the per-burst meta stream from the packet chopper and allocates a fixed-size slot in a circular DDR buffer for each burst.
- Issues the matching AXI4 write-address command, tracks write responses, and, once each burst is committed, hands a descriptor to the read side.
- Gates new bursts on free buffer slots and on an outstanding-transaction limit. The W channel is driven directly by the chopper and is not touched here.

Parameters:
- TDATA_BYTES, 8, stream and AXI data width in bytes; power of 2.
- ADDR_WIDTH, 32, AXI address width.
- BASE_ADDR, 0, byte address of the buffer. Must be aligned to BUF_BYTES.
- BUF_BYTES, 65536, buffer size; power of 2 and multiple of SLOT_BYTES.
- MAX_BURST_LEN, 256, beats per slot. SLOT_BYTES = MAX_BURST_LEN*TDATA_BYTES must be ≤ 4096.
- TID_WIDTH, 4, tid width.
- TDEST_WIDTH, 1, tdest width.
- MAX_OUTSTANDING, 8, AW commands that may await B; power of 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- meta_tvalid  in  1  burst meta valid.
- meta_tready  out  1  burst meta accepted.
- meta_tdata  in  16  [7:0] beats-1, [15:8] valid bytes in last beat.
- meta_tid  in  TID_WIDTH  packet tid.
- meta_tdest  in  TDEST_WIDTH  packet tdest.
- m_axi_awvalid  out  1  AXI write-address valid.
- m_axi_awready  in  1  AXI write-address ready.
- m_axi_awaddr  out  ADDR_WIDTH  slot address.
- m_axi_awlen  out  8  burst length-1.
- m_axi_awsize  out  3  log2(TDATA_BYTES).
- m_axi_awburst  out  2  constant INCR (2'b01).
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_bresp  in  2  write response code.
- desc_tvalid  out  1  committed-burst descriptor valid.
- desc_tready  in  1  descriptor accepted.
- desc_tdata  out  ADDR_WIDTH+16  {bytes_last[7:0], len[7:0], addr}.
- desc_tid  out  TID_WIDTH  tid.
- desc_tdest  out  TDEST_WIDTH  tdest.
- release_valid  in  1  one-cycle pulse: read side freed one slot.
- slots_used  out  clog2(NUM_SLOTS)+1  occupied slots, NUM_SLOTS = BUF_BYTES/SLOT_BYTES.
- wr_err  out  1  sticky: a non-OKAY bresp was seen.

Behaviour:
- Reset values: all valids 0, m_axi_bready 0, wr_ptr 0, slots_used 0, outstanding 0, wr_err 0, descriptor FIFO empty.
- AW FSM has two states, IDLE and ADDR.
- meta_tready = (state==IDLE) && slots_used<NUM_SLOTS && outstanding<MAX_OUTSTANDING.
- On a meta handshake:
  - Register awaddr = BASE_ADDR + wr_ptr*SLOT_BYTES and awlen = meta_tdata[7:0].
  - Latch bytes_last, tid and tdest.
  - Go to ADDR with awvalid=1 on the next cycle. Latency is 1 cycle from meta handshake to awvalid.
  - slots_used increments. wr_ptr increments, wrapping NUM_SLOTS-1→0.
- ADDR state:
  - awvalid and all AW fields are held stable until awready.
  - On the AW handshake, push {awaddr, awlen, bytes_last, tid, tdest} into the descriptor FIFO (depth MAX_OUTSTANDING), increment outstanding, return to IDLE.
  - Peak throughput is one burst per 2 cycles.
- B path:
  - m_axi_bready = FIFO not empty && (!desc_tvalid || desc_tready).
  - On a B handshake, pop the FIFO head into the desc output register (desc_tvalid=1 next cycle) and decrement outstanding.
  - B responses are in order (single AXI ID), so the FIFO head always matches the B.
- B handshake and AW handshake in the same cycle: outstanding is unchanged; push and pop both occur.
- bresp != 2'b00: set wr_err (cleared only by reset). The descriptor is still forwarded so that slot accounting stays consistent.
- desc_tvalid holds with stable data until desc_tready.
- release_valid:
  - Decrements slots_used.
  - Simultaneous with a meta accept: slots_used is unchanged.
  - release_valid while slots_used==0: ignored.
- Full (slots_used==NUM_SLOTS) or outstanding==MAX_OUTSTANDING: meta_tready=0. A command already in ADDR still completes.
- Reset mid-operation discards all in-flight state. The environment must also reset the memory and the read side.

Decomposition:
- vfifo_pkg holds:
  - desc_t struct {addr, len, bytes_last, tid, tdest};
  - AXI constants BURST_INCR=2'b01 and RESP_OKAY=2'b00;
  - a function computing awsize from TDATA_BYTES.
- One sub-module: vfifo_desc_fifo, a synchronous FIFO of desc_t with depth MAX_OUTSTANDING, push/pop/full/empty.

Test Plan:
- Single meta {len=3, bytes=8, tid=2}, awready=1, B OKAY → awaddr=BASE, awlen=3, awsize=3, awburst=1; descriptor {addr=BASE, len=3, bytes_last=8, tid=2}; slots_used=1.
- 33 metas without release (NUM_SLOTS=32), B returned promptly → addresses step by 2048 and meta_tready=0 after the 32nd; one release pulse → the 33rd is issued at awaddr=BASE (wrap).
- Hold bvalid=0 and awready=1 → exactly 8 AW commands issued, then meta_tready=0; one B → exactly one further AW.
- awready stalled 5 cycles → awvalid held with awaddr/awlen stable; no second meta accepted.
- desc_tready=0 with bvalid asserted → bready drops once the desc register is full; no descriptor is lost or duplicated after desc_tready rises.
- bresp=2'b10 on the 2nd burst → wr_err=1 and stays 1; the descriptor is still emitted; release_valid coincident with meta accept → slots_used unchanged.

Source files
------------

// File: rtl/vfifo_pkg.sv
// vfifo_pkg: descriptor type, AXI constants and the AWSIZE helper shared by the write-side sequencer.
// The desc_t field widths set the widest address, tid and tdest that an instance can carry.
package vfifo_pkg;
   localparam int DESC_ADDR_W  = 32;
   localparam int DESC_TID_W   = 4;
   localparam int DESC_TDEST_W = 1;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   typedef struct packed {
      logic [DESC_ADDR_W-1:0]  addr;
      logic [7:0]              len;
      logic [7:0]              bytes_last;
      logic [DESC_TID_W-1:0]   tid;
      logic [DESC_TDEST_W-1:0] tdest;
   } desc_t;
   function automatic logic [2:0] axi_size(input int bytes);
      return 3'($clog2(bytes));
   endfunction
endpackage

// File: rtl/vfifo_wr_scheduler_if.sv
// vfifo_wr_scheduler_if: groups the handshake buses of the write-side sequencer.
// Buses: meta stream (in), AXI4 AW and B channels (out/in), and the descriptor stream to the read side (out).
// The master modport is the sequencer's view. The slave modport is the environment's view.
interface vfifo_wr_scheduler_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 1
);
   logic                     meta_tvalid, meta_tready;
   logic [15:0]              meta_tdata;
   logic [TID_WIDTH-1:0]     meta_tid;
   logic [TDEST_WIDTH-1:0]   meta_tdest;
   logic                     m_axi_awvalid, m_axi_awready;
   logic [ADDR_WIDTH-1:0]    m_axi_awaddr;
   logic [7:0]               m_axi_awlen;
   logic [2:0]               m_axi_awsize;
   logic [1:0]               m_axi_awburst;
   logic                     m_axi_bvalid, m_axi_bready;
   logic [1:0]               m_axi_bresp;
   logic                     desc_tvalid, desc_tready;
   logic [ADDR_WIDTH+15:0]   desc_tdata;
   logic [TID_WIDTH-1:0]     desc_tid;
   logic [TDEST_WIDTH-1:0]   desc_tdest;
   modport master (
      input  meta_tvalid, meta_tdata, meta_tid, meta_tdest, m_axi_awready,
             m_axi_bvalid, m_axi_bresp, desc_tready,
      output meta_tready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
             m_axi_awburst, m_axi_bready, desc_tvalid, desc_tdata, desc_tid, desc_tdest
   );
   modport slave (
      output meta_tvalid, meta_tdata, meta_tid, meta_tdest, m_axi_awready,
             m_axi_bvalid, m_axi_bresp, desc_tready,
      input  meta_tready, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
             m_axi_awburst, m_axi_bready, desc_tvalid, desc_tdata, desc_tid, desc_tdest
   );
endinterface

// File: rtl/vfifo_desc_fifo.sv
// vfifo_desc_fifo: synchronous FIFO of descriptors for bursts whose AW has been issued and whose B is pending.
// Ports: aclk and aresetn (async, active-low), push/din, pop/dout (dout shows the head), full and empty.
// DEPTH must be a power of 2 and at least 2.
module vfifo_desc_fifo import vfifo_pkg::*; #(
   parameter int DEPTH = 8
) (
   input  logic  aclk,
   input  logic  aresetn,
   input  logic  push,
   input  desc_t din,
   input  logic  pop,
   output desc_t dout,
   output logic  full,
   output logic  empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   desc_t mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   always_comb begin
      wp_d = wp_q + PW'(push && !full);
      rp_d = rp_q + PW'(pop && !empty);
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   always_ff @(posedge aclk)
      if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
   // The pointers carry one extra wrap bit, so equal pointers mean empty.
   // A difference only in the wrap bit means full.
   assign empty = wp_q == rp_q;
   assign full  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
   assign dout  = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/vfifo_wr_scheduler.sv
// vfifo_wr_scheduler: allocates DDR ring-buffer slots for chopped bursts and issues the AXI4 AW commands.
// It forwards each committed burst to the read side as a descriptor once its B response arrives.
// Ports: aclk and aresetn (async, active-low).
//        bus (master): meta in, AW/B out, descriptor out.
//        release_valid: pulse from the read side that frees one slot.
//        slots_used: number of occupied slots.
//        wr_err: sticky flag for a non-OKAY bresp.
module vfifo_wr_scheduler import vfifo_pkg::*; #(
   parameter int                    TDATA_BYTES     = 8,
   parameter int                    ADDR_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                    BUF_BYTES       = 65536,
   parameter int                    MAX_BURST_LEN   = 256,
   parameter int                    TID_WIDTH       = 4,
   parameter int                    TDEST_WIDTH     = 1,
   parameter int                    MAX_OUTSTANDING = 8,
   localparam int                   NUM_SLOTS       = BUF_BYTES / (MAX_BURST_LEN * TDATA_BYTES),
   localparam int                   SW              = $clog2(NUM_SLOTS) + 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   vfifo_wr_scheduler_if.master  bus,
   input  logic                  release_valid,
   output logic [SW-1:0]         slots_used,
   output logic                  wr_err
);
   localparam int SLOT_BYTES = MAX_BURST_LEN * TDATA_BYTES;
   localparam int PW = $clog2(NUM_SLOTS);
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   typedef enum logic {IDLE, ADDR} state_t;
   state_t                 state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [SW-1:0]          slots_q, slots_d;
   logic [OW-1:0]          outst_q, outst_d;
   logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
   logic [7:0]             awlen_q, awlen_d, bytes_last_q, bytes_last_d;
   logic [TID_WIDTH-1:0]   tid_q, tid_d;
   logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
   logic                   desc_valid_q, desc_valid_d, wr_err_q, wr_err_d;
   desc_t                  desc_q, desc_d, fifo_din, fifo_dout;
   logic                   fifo_full, fifo_empty, meta_fire, aw_fire, b_fire, rel;
   assign meta_fire = bus.meta_tvalid && bus.meta_tready;
   assign aw_fire   = bus.m_axi_awvalid && bus.m_axi_awready;
   assign b_fire    = bus.m_axi_bvalid && bus.m_axi_bready;
   // A release pulse while no slot is held is ignored, so the count cannot underflow.
   assign rel       = release_valid && slots_q != '0;
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      awaddr_d     = awaddr_q;
      awlen_d      = awlen_q;
      bytes_last_d = bytes_last_q;
      tid_d        = tid_q;
      tdest_d      = tdest_q;
      if (meta_fire) begin
         state_d      = ADDR;
         awaddr_d     = BASE_ADDR + ADDR_WIDTH'(wr_ptr_q) * ADDR_WIDTH'(SLOT_BYTES);
         awlen_d      = bus.meta_tdata[7:0];
         bytes_last_d = bus.meta_tdata[15:8];
         tid_d        = bus.meta_tid;
         tdest_d      = bus.meta_tdest;
         wr_ptr_d     = wr_ptr_q == PW'(NUM_SLOTS - 1) ? '0 : wr_ptr_q + 1'b1;
      end
      if (aw_fire) state_d = IDLE;
      slots_d      = slots_q + SW'(meta_fire) - SW'(rel);
      outst_d      = outst_q + OW'(aw_fire) - OW'(b_fire);
      desc_valid_d = b_fire || (desc_valid_q && !bus.desc_tready);
      desc_d       = b_fire ? fifo_dout : desc_q;
      wr_err_d     = wr_err_q || (b_fire && bus.m_axi_bresp != RESP_OKAY);
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         slots_q      <= '0;
         outst_q      <= '0;
         awaddr_q     <= '0;
         awlen_q      <= '0;
         bytes_last_q <= '0;
         tid_q        <= '0;
         tdest_q      <= '0;
         desc_valid_q <= 1'b0;
         desc_q       <= '0;
         wr_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         slots_q      <= slots_d;
         outst_q      <= outst_d;
         awaddr_q     <= awaddr_d;
         awlen_q      <= awlen_d;
         bytes_last_q <= bytes_last_d;
         tid_q        <= tid_d;
         tdest_q      <= tdest_d;
         desc_valid_q <= desc_valid_d;
         desc_q       <= desc_d;
         wr_err_q     <= wr_err_d;
      end
   assign fifo_din = '{addr: DESC_ADDR_W'(awaddr_q), len: awlen_q, bytes_last: bytes_last_q,
                       tid: DESC_TID_W'(tid_q), tdest: DESC_TDEST_W'(tdest_q)};
   vfifo_desc_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (aw_fire),
      .din     (fifo_din),
      .pop     (b_fire),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );
   // The FIFO never holds more than MAX_OUTSTANDING entries, so fifo_full never adds a constraint beyond the outstanding limit.
   assign bus.meta_tready   = state_q == IDLE && slots_q < SW'(NUM_SLOTS) &&
                              outst_q < OW'(MAX_OUTSTANDING) && !fifo_full;
   assign bus.m_axi_awvalid = state_q == ADDR;
   assign bus.m_axi_awaddr  = awaddr_q;
   assign bus.m_axi_awlen   = awlen_q;
   assign bus.m_axi_awsize  = axi_size(TDATA_BYTES);
   assign bus.m_axi_awburst = BURST_INCR;
   // B is accepted only when its descriptor has a place to go: the output register is empty or is being drained.
   assign bus.m_axi_bready  = !fifo_empty && (!desc_valid_q || bus.desc_tready);
   assign bus.desc_tvalid   = desc_valid_q;
   assign bus.desc_tdata    = {desc_q.bytes_last, desc_q.len, ADDR_WIDTH'(desc_q.addr)};
   assign bus.desc_tid      = TID_WIDTH'(desc_q.tid);
   assign bus.desc_tdest    = TDEST_WIDTH'(desc_q.tdest);
   assign slots_used        = slots_q;
   assign wr_err            = wr_err_q;
endmodule
